ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
Instruction fetch stage for the lab MIPS core, sitting at the other end of the execute stage's control-flow interface. It consumes the branch and jump decisions that execute produces (do_branch/branch_addr, do_jump/jump_addr). It owns the PC register, issues request/acknowledge reads to instruction memory, and presents one instruction at a time to decode with a valid/ready handshake. Redirects squash any in-flight fetch.

Parameters:
RESET_PC, 32'h00400000, PC value loaded on reset.

Ports:
clock  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
imem_req  output  1  instruction memory read request.
imem_addr  output  32  word-aligned fetch address; equals pc.
imem_ack  input  1  memory response strobe; imem_rdata valid this cycle.
imem_rdata  input  32  fetched instruction word.
inst_valid  output  1  instruction/pc/pc4 valid for decode.
inst_ready  input  1  decode accepts instruction this cycle.
instruction  output  32  registered fetched word.
pc  output  32  address of the fetch in progress, or of the presented instruction.
pc4  output  32  pc + 4, combinational.
do_branch  input  1  branch taken, from execute.
branch_addr  input  32  branch target.
do_jump  input  1  j/jal taken, from execute.
jump_addr  input  32  absolute jump target.
misaligned  output  1  one-cycle pulse: redirect target had nonzero bits [1:0].

Behaviour:
- Reset (async, any state): pc=RESET_PC, state=IDLE, inst_valid=0, imem_req=0, instruction=0, misaligned=0, squash=0, pending target=0. Any imem_ack arriving after reset is ignored unless the unit is in REQ.
- States: IDLE, REQ, VALID.
- IDLE: imem_req=0. Moves to REQ on the next edge, so imem_req rises 1 cycle after reset release.
- REQ: imem_req=1. imem_addr=pc, held stable until ack. imem_ack may arrive in the same cycle req first rises (0 wait) or any number of cycles later.
  - On ack with squash=0: instruction<=imem_rdata, inst_valid<=1, go to VALID.
  - On ack with squash=1: discard the data, pc<=pending target, squash<=0, go to IDLE. imem_req is low for exactly 1 cycle before the new request.
- VALID: inst_valid=1. instruction and pc are held while inst_ready=0. imem_req=0, so only one request is outstanding at a time.
  - inst_ready=1 with no redirect: pc<=pc+4, inst_valid<=0, go to REQ.
- Redirect: redirect = do_branch | do_jump. Target = jump_addr if do_jump, else branch_addr; jump has priority. Target bits [1:0] are forced to 00. misaligned pulses the next cycle if the raw bits were nonzero.
  - In IDLE: pc<=target; next state REQ.
  - In VALID, regardless of inst_ready: pc<=target, inst_valid<=0, go to REQ. The redirect consumes the presented instruction.
  - In REQ without ack: pending target<=target, squash<=1, stay in REQ. The current request stays asserted with the old address until its ack.
  - In REQ with ack in the same cycle: data is discarded, pc<=target, go to IDLE.
  - Repeated redirects while squash=1: the latest target overwrites the pending target.
- imem_ack outside REQ is ignored.
- Throughput: 1 instruction per 2 cycles with zero-wait memory and inst_ready held high.
- pc+4 wraps modulo 2^32: 0xFFFFFFFC+4 = 0x00000000. No overflow flag.

Test Plan:
1. Reset release; 0-wait memory returns 0x8C080004 at every address; inst_ready=1 -> imem_addr sequence 0x00400000, 0x00400004, 0x00400008. inst_valid high on alternate cycles; pc4=0x00400004 while pc=0x00400000.
2. Hold inst_ready=0 for 5 cycles in VALID -> instruction, pc and inst_valid=1 are stable, and imem_req=0 throughout.
3. In VALID, do_branch=1, branch_addr=0x00400040 -> next request has imem_addr=0x00400040 and the old instruction is never re-presented.
4. With 3-cycle ack latency, pulse do_jump=1, jump_addr=0x00400100 one cycle after req rises -> that response is discarded with no inst_valid. After 1 idle cycle, imem_addr=0x00400100.
5. do_jump and do_branch asserted together, jump_addr=0x00400042, branch_addr=0x00400080 -> fetch goes to 0x00400040 and misaligned pulses for exactly 1 cycle.
6. Assert reset mid-REQ, then release and deliver a stale imem_ack -> outputs return to their reset values; after restart the first instruction delivered comes from the new request at 0x00400000.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem read at a time and hands
// instructions to decode over valid/ready. Execute-stage redirects squash in-flight fetches.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00400000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  input  logic        do_branch,
  input  logic [31:0] branch_addr,
  input  logic        do_jump,
  input  logic [31:0] jump_addr,
  output logic        misaligned
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_VALID} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pend_q, pend_d;
  logic        squash_q, squash_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic        misal_q, misal_d;

  logic        redirect;
  logic [31:0] target_raw;
  logic [31:0] target;

  // Jump wins over branch; the low two bits are dropped but reported.
  assign redirect   = do_branch | do_jump;
  assign target_raw = do_jump ? jump_addr : branch_addr;
  assign target     = {target_raw[31:2], 2'b00};

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pend_d   = pend_q;
    squash_d = squash_q;
    req_d    = req_q;
    valid_d  = valid_q;
    misal_d  = redirect & (|target_raw[1:0]);

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        req_d   = 1'b1;
        if (redirect) pc_d = target;
      end
      S_REQ: begin
        if (imem_ack) begin
          req_d = 1'b0;
          if (redirect) begin
            // Fresh redirect supersedes both the data and any older pending target.
            pc_d     = target;
            squash_d = 1'b0;
            state_d  = S_IDLE;
          end else if (squash_q) begin
            pc_d     = pend_q;
            squash_d = 1'b0;
            state_d  = S_IDLE;
          end else begin
            instr_d = imem_rdata;
            valid_d = 1'b1;
            state_d = S_VALID;
          end
        end else if (redirect) begin
          // Address must stay stable until ack, so park the target.
          pend_d   = target;
          squash_d = 1'b1;
        end
      end
      S_VALID: begin
        if (redirect) begin
          pc_d    = target;
          valid_d = 1'b0;
          req_d   = 1'b1;
          state_d = S_REQ;
        end else if (inst_ready) begin
          pc_d    = pc_q + 32'd4;
          valid_d = 1'b0;
          req_d   = 1'b1;
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= 32'h0;
      pend_q   <= 32'h0;
      squash_q <= 1'b0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      misal_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pend_q   <= pend_d;
      squash_q <= squash_d;
      req_q    <= req_d;
      valid_q  <= valid_d;
      misal_q  <= misal_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign inst_valid  = valid_q;
  assign instruction = instr_q;
  assign pc          = pc_q;
  assign pc4         = pc_q + 32'd4;
  assign misaligned  = misal_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: expected fetch addresses and delivered
// instructions are queued by the stimulus and popped by independent monitors.
module tb_ifetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        do_branch;
  logic [31:0] branch_addr;
  logic        do_jump;
  logic [31:0] jump_addr;
  logic        misaligned;

  int n_cmp = 0;
  int n_err = 0;

  int   lat = 0;
  logic mode = 1'b0;
  logic stale_ack = 1'b0;
  int   wait_cnt = 0;
  logic req_prev = 1'b0;

  logic [31:0] exp_addr[$];
  logic [63:0] exp_inst[$];

  ifetch_unit #(.RESET_PC(32'h00400000)) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .instruction(instruction),
    .pc(pc), .pc4(pc4),
    .do_branch(do_branch), .branch_addr(branch_addr),
    .do_jump(do_jump), .jump_addr(jump_addr),
    .misaligned(misaligned)
  );

  always #5 clock = ~clock;

  // Memory: ack after 'lat' cycles of request; data either constant or address-tagged.
  assign imem_ack   = (imem_req && (wait_cnt == lat)) || stale_ack;
  assign imem_rdata = mode ? (32'h24000000 | {16'h0, imem_addr[15:0]}) : 32'h8C080004;

  always @(posedge clock) begin
    if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Request monitor: each new request must match the next expected address.
  always @(negedge clock) begin
    if (!reset && imem_req && !req_prev) begin
      if (exp_addr.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL req_extra: got addr %h expected no request", imem_addr);
      end else begin
        check("req_addr", {32'h0, imem_addr}, {32'h0, exp_addr.pop_front()});
      end
    end
    req_prev <= imem_req;
  end

  // Instruction monitor: a presented instruction is consumed by ready or a redirect.
  always @(negedge clock) begin
    if (!reset && inst_valid && (inst_ready || do_branch || do_jump)) begin
      if (exp_inst.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL inst_extra: got pc %h inst %h expected none", pc, instruction);
      end else begin
        check("inst_pc_word", {pc, instruction}, exp_inst.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; inst_ready = 1'b0;
    do_branch = 1'b0; branch_addr = 32'h0; do_jump = 1'b0; jump_addr = 32'h0;
    repeat (2) step();
    check("rst_pc", 64'(pc), 64'h00400000);
    check("rst_req", 64'(imem_req), 64'h0);
    check("rst_valid", 64'(inst_valid), 64'h0);
    check("rst_instr", 64'(instruction), 64'h0);
    check("rst_misal", 64'(misaligned), 64'h0);

    // 1: zero-wait streaming
    exp_addr.push_back(32'h00400000);
    exp_addr.push_back(32'h00400004);
    exp_addr.push_back(32'h00400008);
    exp_inst.push_back({32'h00400000, 32'h8C080004});
    exp_inst.push_back({32'h00400004, 32'h8C080004});
    exp_inst.push_back({32'h00400008, 32'h8C080004});
    inst_ready = 1'b1;
    reset = 1'b0;
    step();
    check("t1_pc", 64'(pc), 64'h00400000);
    check("t1_pc4", 64'(pc4), 64'h00400004);
    check("t1_valid0", 64'(inst_valid), 64'h0);
    for (int i = 1; i < 6; i++) begin
      step();
      check("t1_valid_alt", 64'(inst_valid), 64'(i % 2));
    end
    inst_ready = 1'b0;

    // 2: stall in VALID
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_instr", 64'(instruction), 64'h8C080004);
      check("t2_pc", 64'(pc), 64'h00400008);
      check("t2_valid", 64'(inst_valid), 64'h1);
      check("t2_req", 64'(imem_req), 64'h0);
    end

    // 3: branch out of VALID
    mode = 1'b1;
    do_branch = 1'b1; branch_addr = 32'h00400040;
    exp_addr.push_back(32'h00400040);
    exp_inst.push_back({32'h00400040, 32'h24000040});
    step();
    do_branch = 1'b0;
    check("t3_valid_drop", 64'(inst_valid), 64'h0);
    check("t3_addr", 64'(imem_addr), 64'h00400040);
    step();
    check("t3_valid", 64'(inst_valid), 64'h1);

    // 4: jump while a 3-cycle fetch is in flight
    lat = 3; inst_ready = 1'b1;
    exp_addr.push_back(32'h00400044);
    step();
    inst_ready = 1'b0;
    step();
    do_jump = 1'b1; jump_addr = 32'h00400100;
    step();
    do_jump = 1'b0;
    check("t4_valid_a", 64'(inst_valid), 64'h0);
    step();
    check("t4_valid_b", 64'(inst_valid), 64'h0);
    check("t4_addr_held", 64'(imem_addr), 64'h00400044);
    check("t4_req_held", 64'(imem_req), 64'h1);
    exp_addr.push_back(32'h00400100);
    exp_inst.push_back({32'h00400100, 32'h24000100});
    step();
    check("t4_idle_req", 64'(imem_req), 64'h0);
    check("t4_idle_valid", 64'(inst_valid), 64'h0);
    step();
    check("t4_req", 64'(imem_req), 64'h1);
    check("t4_addr", 64'(imem_addr), 64'h00400100);
    for (int k = 0; k < 10 && !inst_valid; k++) step();
    check("t4_wait_valid", 64'(inst_valid), 64'h1);

    // 5: jump+branch together, misaligned jump target
    lat = 0;
    do_jump = 1'b1; jump_addr = 32'h00400042;
    do_branch = 1'b1; branch_addr = 32'h00400080;
    exp_addr.push_back(32'h00400040);
    exp_inst.push_back({32'h00400040, 32'h24000040});
    step();
    do_jump = 1'b0; do_branch = 1'b0;
    check("t5_misal_hi", 64'(misaligned), 64'h1);
    check("t5_addr", 64'(imem_addr), 64'h00400040);
    check("t5_valid", 64'(inst_valid), 64'h0);
    step();
    check("t5_misal_lo", 64'(misaligned), 64'h0);
    check("t5_valid_hi", 64'(inst_valid), 64'h1);

    // 6: reset mid-REQ, then a stale ack
    lat = 3; inst_ready = 1'b1;
    exp_addr.push_back(32'h00400044);
    step();
    inst_ready = 1'b0;
    step();
    reset = 1'b1;
    #1;
    check("t6_rst_pc", 64'(pc), 64'h00400000);
    check("t6_rst_req", 64'(imem_req), 64'h0);
    check("t6_rst_valid", 64'(inst_valid), 64'h0);
    check("t6_rst_instr", 64'(instruction), 64'h0);
    check("t6_rst_misal", 64'(misaligned), 64'h0);
    step();
    lat = 0; stale_ack = 1'b1; reset = 1'b0;
    exp_addr.push_back(32'h00400000);
    exp_inst.push_back({32'h00400000, 32'h24000000});
    step();
    stale_ack = 1'b0;
    check("t6_stale_ignored", 64'(inst_valid), 64'h0);
    check("t6_req", 64'(imem_req), 64'h1);
    check("t6_addr", 64'(imem_addr), 64'h00400000);
    step();
    check("t6_valid", 64'(inst_valid), 64'h1);
    exp_addr.push_back(32'h00400004);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    step();
    check("t6_next_valid", 64'(inst_valid), 64'h1);
    check("t6_next_pc", 64'(pc), 64'h00400004);

    step();
    check("addr_queue_drained", 64'(exp_addr.size()), 64'h0);
    check("inst_queue_drained", 64'(exp_inst.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
